// File: rtl/prog_truth_table.sv
// rtl/prog_truth_table.sv - serially programmable N-input truth table with valid/ready evaluation
// The active table only changes by a whole-table commit of the shadow, so evaluation never sees a partial load.
module prog_truth_table #(
  parameter int N_IN = 3,
  parameter int TT_W = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_bits,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_bit,
  input  logic            out_ready,
  output logic [TT_W-1:0] table_out
);
  localparam int CNT_W = $clog2(TT_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TT_W - 1);

  typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [TT_W-1:0]  r_shadow;
  logic [TT_W-1:0]  w_next_shadow;
  logic [TT_W-1:0]  r_table;
  logic             r_cfg_done;
  logic             r_out_valid;
  logic             r_out_bit;
  logic             w_cfg_acc;
  logic             w_commit;
  logic             w_in_ready;
  logic             w_in_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // cfg_start always wins in LOAD, even over the final bit, so a restart never commits.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_next_shadow = r_shadow;
    w_cfg_acc     = 1'b0;
    w_commit      = 1'b0;
    cfg_ready     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (cfg_start) begin
          w_next_state = S_LOAD;
          w_next_cnt   = '0;
        end
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        w_cfg_acc = cfg_valid;
        if (cfg_start) begin
          w_next_cnt = '0;
        end else if (w_cfg_acc) begin
          w_next_shadow[r_cnt[CNT_W-2:0]] = cfg_bit;
          if (r_cnt == LAST_ROW) begin
            w_commit     = 1'b1;
            w_next_state = S_RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_next_state = S_RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_in_acc   = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow    <= '0;
      r_table     <= '0;
      r_cfg_done  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
    end else begin
      r_shadow   <= w_next_shadow;
      r_cfg_done <= w_commit;
      if (w_commit) begin
        r_table <= w_next_shadow;
      end
      if (w_in_acc) begin
        r_out_valid <= 1'b1;
        r_out_bit   <= r_table[in_bits];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign cfg_done  = r_cfg_done;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign table_out = r_table;

endmodule

// File: tb/tb_prog_truth_table.sv
// tb/tb_prog_truth_table.sv - directed self-checking bench for prog_truth_table (N_IN=3 and N_IN=4)
module tb_prog_truth_table;
  logic        clk;
  logic        rst;
  logic        cfg_start, cfg_valid, cfg_bit, cfg_ready, cfg_done;
  logic        in_valid, in_ready, out_valid, out_bit, out_ready;
  logic [2:0]  in_bits;
  logic [7:0]  table_out;
  logic        cfg_start4, cfg_valid4, cfg_bit4, cfg_ready4, cfg_done4;
  logic        in_valid4, in_ready4, out_valid4, out_bit4, out_ready4;
  logic [3:0]  in_bits4;
  logic [15:0] table_out4;

  int checks = 0;
  int errors = 0;

  prog_truth_table #(.N_IN(3)) dut3 (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .table_out(table_out)
  );

  prog_truth_table #(.N_IN(4)) dut4 (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start4), .cfg_valid(cfg_valid4), .cfg_bit(cfg_bit4),
    .cfg_ready(cfg_ready4), .cfg_done(cfg_done4),
    .in_valid(in_valid4), .in_bits(in_bits4), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_bit(out_bit4), .out_ready(out_ready4),
    .table_out(table_out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Serially drives n bits of val (row 0 first) into dut3 and counts cfg_done pulses seen.
  task automatic load3(input logic [7:0] val, input int n, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = val[k];
      step;
      if (cfg_done === 1'b1) dones++;
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    checks++; if (table_out !== 8'h00) begin errors++; $display("FAIL reset_table got %h exp 00", table_out); end
    checks++; if (out_valid !== 1'b0 || out_bit !== 1'b0) begin errors++; $display("FAIL reset_out got v=%b b=%b exp v=0 b=0", out_valid, out_bit); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_cfg_done got %b exp 0", cfg_done); end
    checks++; if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got in=%b cfg=%b exp in=1 cfg=0", in_ready, cfg_ready); end
    checks++; if (table_out4 !== 16'h0000) begin errors++; $display("FAIL reset_table4 got %h exp 0000", table_out4); end
  endtask

  task automatic test_reset_eval;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 3'b101;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eval0_in_ready got %b exp 1", in_ready); end
    step;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin errors++; $display("FAIL eval0_result got v=%b b=%b exp v=1 b=0", out_valid, out_bit); end
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eval0_clear got %b exp 0", out_valid); end
  endtask

  task automatic test_parity;
    int d;
    logic [7:0] exp_tt;
    exp_tt = 8'h96;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    checks++; if (cfg_ready !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL load_ready got cfg=%b in=%b exp cfg=1 in=0", cfg_ready, in_ready); end
    load3(8'h96, 7, d);
    checks++; if (d != 0 || table_out !== 8'h00) begin errors++; $display("FAIL partial_load got done=%0d tt=%h exp done=0 tt=00", d, table_out); end
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step;
    cfg_valid = 1'b0;
    checks++; if (cfg_done !== 1'b1 || table_out !== 8'h96) begin errors++; $display("FAIL parity_commit got done=%b tt=%h exp done=1 tt=96", cfg_done, table_out); end
    checks++; if (in_ready !== 1'b1 || cfg_ready !== 1'b0) begin errors++; $display("FAIL parity_run got in=%b cfg=%b exp in=1 cfg=0", in_ready, cfg_ready); end
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      in_bits  = 3'(v);
      step;
      checks++; if (out_valid !== 1'b1 || out_bit !== exp_tt[v]) begin errors++; $display("FAIL parity_row%0d got v=%b b=%b exp v=1 b=%b", v, out_valid, out_bit, exp_tt[v]); end
      if (v == 0) begin
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_done_pulse got %b exp 0", cfg_done); end
      end
    end
    in_valid = 1'b0;
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL parity_drain got %b exp 0", out_valid); end
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    repeat (3) step;
    cfg_valid = 1'b0;
    checks++; if (table_out !== 8'h96 || cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL cfg_in_run got tt=%h rdy=%b done=%b exp tt=96 rdy=0 done=0", table_out, cfg_ready, cfg_done); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 3'b001;
    step;
    checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL bp_first got v=%b b=%b exp v=1 b=1", out_valid, out_bit); end
    in_bits = 3'b011;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b exp 0", i, in_ready); end
      step;
      checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got v=%b b=%b exp v=1 b=1", i, out_valid, out_bit); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    step;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_bit !== 1'b0) begin errors++; $display("FAIL bp_second got v=%b b=%b exp v=1 b=0", out_valid, out_bit); end
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_restart;
    int d1, d2, total;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    load3(8'h00, 4, d1);
    checks++; if (table_out !== 8'h96) begin errors++; $display("FAIL restart_partial got %h exp 96", table_out); end
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    load3(8'hFF, 8, d2);
    total = d1 + d2;
    step;
    if (cfg_done === 1'b1) total++;
    checks++; if (total != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", total); end
    checks++; if (table_out !== 8'hFF) begin errors++; $display("FAIL restart_table got %h exp ff", table_out); end
  endtask

  task automatic test_start_with_last;
    int d;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bits   = 3'b101;
    cfg_start = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_accept_ready got %b exp 1", in_ready); end
    step;
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_bit !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL start_old_table got v=%b b=%b rdy=%b exp v=1 b=1 rdy=1", out_valid, out_bit, cfg_ready); end
    step;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load_hold_result got %b exp 1", out_valid); end
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_drain got %b exp 0", out_valid); end
    load3(8'h00, 7, d);
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    checks++; if (cfg_done !== 1'b0 || table_out !== 8'hFF || cfg_ready !== 1'b1) begin errors++; $display("FAIL start_last got done=%b tt=%h rdy=%b exp done=0 tt=ff rdy=1", cfg_done, table_out, cfg_ready); end
    load3(8'h00, 7, d);
    checks++; if (d != 0 || table_out !== 8'hFF) begin errors++; $display("FAIL cnt_zero_partial got done=%0d tt=%h exp done=0 tt=ff", d, table_out); end
    load3(8'h00, 1, d);
    checks++; if (d != 1 || table_out !== 8'h00) begin errors++; $display("FAIL cnt_zero_commit got done=%0d tt=%h exp done=1 tt=00", d, table_out); end
  endtask

  task automatic test_reset_mid_load;
    int d;
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    load3(8'hA5, 8, d);
    checks++; if (table_out !== 8'hA5) begin errors++; $display("FAIL preload_a5 got %h exp a5", table_out); end
    cfg_start = 1'b1;
    step;
    cfg_start = 1'b0;
    load3(8'hFF, 5, d);
    rst       = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    step;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    checks++; if (table_out !== 8'h00 || cfg_done !== 1'b0) begin errors++; $display("FAIL rst_load got tt=%h done=%b exp tt=00 done=0", table_out, cfg_done); end
    checks++; if (cfg_ready !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_load_state got cfg=%b in=%b exp cfg=0 in=1", cfg_ready, in_ready); end
    step;
    checks++; if (cfg_done !== 1'b0 || table_out !== 8'h00) begin errors++; $display("FAIL rst_load_after got done=%b tt=%h exp done=0 tt=00", cfg_done, table_out); end
  endtask

  task automatic test_n4;
    int d;
    d = 0;
    cfg_start4 = 1'b1;
    step;
    cfg_start4 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cfg_valid4 = 1'b1;
      cfg_bit4   = (k == 15);
      step;
      if (cfg_done4 === 1'b1) d++;
    end
    cfg_valid4 = 1'b0;
    checks++; if (d != 1 || table_out4 !== 16'h8000) begin errors++; $display("FAIL n4_load got done=%0d tt=%h exp done=1 tt=8000", d, table_out4); end
    out_ready4 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      in_valid4 = 1'b1;
      in_bits4  = 4'(v);
      step;
      checks++; if (out_valid4 !== 1'b1 || out_bit4 !== (v == 15)) begin errors++; $display("FAIL n4_row%0d got v=%b b=%b exp v=1 b=%b", v, out_valid4, out_bit4, (v == 15)); end
    end
    in_valid4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_bits = 3'b000; out_ready = 1'b0;
    cfg_start4 = 1'b0; cfg_valid4 = 1'b0; cfg_bit4 = 1'b0;
    in_valid4 = 1'b0; in_bits4 = 4'b0000; out_ready4 = 1'b0;
    test_reset;
    test_reset_eval;
    test_parity;
    test_backpressure;
    test_restart;
    test_start_with_last;
    test_reset_mid_load;
    test_n4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
